// File: rtl/mem_resp_stage.sv
// mem_resp_stage: memory-access pipeline stage between EX and WB.
//
// Holds one entry from EX and waits for its data-memory response, which may
// take any number of cycles. It then extracts the load result (byte, half,
// word or dword, zero- or sign-extended) and hands the entry to WB. When WB
// flushes, responses still owed to cancelled requests are counted and
// dropped as they arrive.
//
// Handshake: a transfer happens on a cycle where the sender's valid and the
// receiver's allowin are both high. Valid never depends on allowin from the
// same side. EX->MS uses es_to_ms_valid/ms_allowin and MS->WB uses
// ms_to_ws_valid/ws_allowin. wb_flush overrides both transfers.
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   es_to_ms_valid/ms_allowin   EX->MS handshake
//   es_*                    entry fields from EX (payload is opaque side-band)
//   data_sram_data_ok/rdata response beat from data memory (in order)
//   ws_allowin, wb_flush    WB back-pressure and exception/ertn flush
//   ms_to_ws_*              registered entry towards WB, plus ms_final_result
//   ms_ex_valid             valid entry carrying an exception
//   ms_fwd_valid/ms_fwd_stall   forwarding status for the dest GPR
//   ms_outst_ovf            sticky flag: discard counter saturated
module mem_resp_stage #(
    parameter int DATA_W    = 32,
    parameter int PAYLOAD_W = 200,
    parameter int MAX_OUTST = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 es_to_ms_valid,
    output logic                 ms_allowin,
    input  logic [PAYLOAD_W-1:0] es_to_ms_payload,
    input  logic                 es_gr_we,
    input  logic [4:0]           es_dest,
    input  logic                 es_mem_req,
    input  logic                 es_is_load,
    input  logic [1:0]           es_ld_size,
    input  logic                 es_ld_sign,
    input  logic [DATA_W-1:0]    es_exe_result,
    input  logic                 es_has_ex,
    input  logic                 data_sram_data_ok,
    input  logic [DATA_W-1:0]    data_sram_rdata,
    input  logic                 ws_allowin,
    input  logic                 wb_flush,
    output logic                 ms_to_ws_valid,
    output logic [PAYLOAD_W-1:0] ms_to_ws_payload,
    output logic                 ms_to_ws_gr_we,
    output logic [4:0]           ms_to_ws_dest,
    output logic [DATA_W-1:0]    ms_final_result,
    output logic                 ms_ex_valid,
    output logic                 ms_fwd_valid,
    output logic                 ms_fwd_stall,
    output logic                 ms_outst_ovf
);

    localparam int OFF_W = $clog2(DATA_W / 8);
    localparam int CNT_W = 4;
    // Masks that align the byte offset down to a half / word boundary.
    localparam int HMASK = (1 << OFF_W) - 2;
    localparam int WMASK = (1 << OFF_W) - 4;

    logic              ms_valid;
    logic              ms_gr_we;
    logic [4:0]        ms_dest;
    logic              ms_mem_req;
    logic              ms_is_load;
    logic [1:0]        ms_ld_size;
    logic              ms_ld_sign;
    logic [DATA_W-1:0] ms_exe_result;
    logic              ms_has_ex;
    logic              resp_got;
    logic [DATA_W-1:0] rbuf;
    logic [CNT_W-1:0]  discard_cnt;

    logic              resp_hit;
    logic              ms_ready_go;
    logic              entry_load;
    logic [CNT_W:0]    inc;
    logic [CNT_W:0]    dec;
    logic [CNT_W:0]    cnt_next;

    logic [DATA_W-1:0] rd;
    logic [OFF_W-1:0]  off;
    logic [OFF_W-1:0]  off_h;
    logic [OFF_W-1:0]  off_w;
    logic [7:0]        byte_v;
    logic [15:0]       half_v;
    logic [31:0]       word_v;
    logic [DATA_W-1:0] ld_ext;

    // While discard_cnt is non-zero the next response belongs to a
    // cancelled request, so the entry must not take it.
    assign resp_hit    = data_sram_data_ok && (discard_cnt == '0) && ms_valid
                         && ms_mem_req && !resp_got;
    assign ms_ready_go = !ms_mem_req || resp_got || resp_hit || ms_has_ex;
    assign ms_allowin  = !ms_valid || (ms_ready_go && ws_allowin);
    assign entry_load  = es_to_ms_valid && ms_allowin && !wb_flush;

    assign ms_to_ws_valid   = ms_valid && ms_ready_go && !wb_flush;
    assign ms_ex_valid      = ms_valid && ms_has_ex;
    assign ms_fwd_valid     = ms_valid && ms_gr_we && ms_ready_go;
    assign ms_fwd_stall     = ms_valid && ms_gr_we && !ms_ready_go;
    assign ms_to_ws_gr_we   = ms_gr_we;
    assign ms_to_ws_dest    = ms_dest;

    // Requests orphaned by a flush: the one MS is still waiting on, and
    // the one EX issued in the flush cycle.
    assign inc = (CNT_W+1)'(wb_flush && ms_valid && ms_mem_req && !resp_got && !resp_hit)
               + (CNT_W+1)'(wb_flush && es_to_ms_valid && es_mem_req);
    assign dec = (CNT_W+1)'(data_sram_data_ok && (discard_cnt != '0));
    assign cnt_next = {1'b0, discard_cnt} + inc - dec;

    // Load extraction; data is bypassed from the bus on the response cycle.
    assign rd     = resp_hit ? data_sram_rdata : rbuf;
    assign off    = ms_exe_result[OFF_W-1:0];
    assign off_h  = off & OFF_W'(HMASK);
    assign off_w  = off & OFF_W'(WMASK);
    assign byte_v = rd[{off,   3'b000} +: 8];
    assign half_v = rd[{off_h, 3'b000} +: 16];
    assign word_v = rd[{off_w, 3'b000} +: 32];

    always_comb begin
        ld_ext = rd;
        case (ms_ld_size)
            2'd0:    ld_ext = ms_ld_sign ? DATA_W'($signed(byte_v)) : DATA_W'(byte_v);
            2'd1:    ld_ext = ms_ld_sign ? DATA_W'($signed(half_v)) : DATA_W'(half_v);
            2'd2:    ld_ext = ms_ld_sign ? DATA_W'($signed(word_v)) : DATA_W'(word_v);
            default: ld_ext = rd;
        endcase
    end

    assign ms_final_result = ms_is_load ? ld_ext : ms_exe_result;

    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid     <= 1'b0;
            ms_gr_we     <= 1'b0;
            ms_mem_req   <= 1'b0;
            ms_has_ex    <= 1'b0;
            resp_got     <= 1'b0;
            rbuf         <= '0;
            discard_cnt  <= '0;
            ms_outst_ovf <= 1'b0;
        end else begin
            if (wb_flush) begin
                ms_valid <= 1'b0;
            end else if (ms_allowin) begin
                ms_valid <= es_to_ms_valid;
            end

            if (entry_load) begin
                ms_to_ws_payload <= es_to_ms_payload;
                ms_gr_we         <= es_gr_we;
                ms_dest          <= es_dest;
                ms_mem_req       <= es_mem_req;
                ms_is_load       <= es_is_load;
                ms_ld_size       <= es_ld_size;
                ms_ld_sign       <= es_ld_sign;
                ms_exe_result    <= es_exe_result;
                ms_has_ex        <= es_has_ex;
                resp_got         <= 1'b0;
                rbuf             <= '0;
            end else if (resp_hit) begin
                resp_got <= 1'b1;
                rbuf     <= data_sram_rdata;
            end

            if (cnt_next > (CNT_W+1)'(MAX_OUTST)) begin
                discard_cnt  <= CNT_W'(MAX_OUTST);
                ms_outst_ovf <= 1'b1;
            end else begin
                discard_cnt <= cnt_next[CNT_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_mem_resp_stage.sv
// Testbench for mem_resp_stage. Instance a: DATA_W=32, MAX_OUTST=4.
// Instance b: DATA_W=64, MAX_OUTST=1. Inputs change on the falling edge and
// outputs are checked 1ns later, well away from the rising edge.
module tb_mem_resp_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- instance a (32-bit) ----------------
    logic         a_reset;
    logic         a_es_to_ms_valid, a_ms_allowin;
    logic [199:0] a_es_to_ms_payload, a_ms_to_ws_payload;
    logic         a_es_gr_we, a_es_mem_req, a_es_is_load, a_es_ld_sign, a_es_has_ex;
    logic [4:0]   a_es_dest, a_ms_to_ws_dest;
    logic [1:0]   a_es_ld_size;
    logic [31:0]  a_es_exe_result, a_data_sram_rdata, a_ms_final_result;
    logic         a_data_ok, a_ws_allowin, a_wb_flush;
    logic         a_ms_to_ws_valid, a_ms_to_ws_gr_we, a_ms_ex_valid;
    logic         a_ms_fwd_valid, a_ms_fwd_stall, a_ms_outst_ovf;

    mem_resp_stage #(.DATA_W(32), .PAYLOAD_W(200), .MAX_OUTST(4)) dut_a (
        .clk(clk), .reset(a_reset),
        .es_to_ms_valid(a_es_to_ms_valid), .ms_allowin(a_ms_allowin),
        .es_to_ms_payload(a_es_to_ms_payload), .es_gr_we(a_es_gr_we),
        .es_dest(a_es_dest), .es_mem_req(a_es_mem_req), .es_is_load(a_es_is_load),
        .es_ld_size(a_es_ld_size), .es_ld_sign(a_es_ld_sign),
        .es_exe_result(a_es_exe_result), .es_has_ex(a_es_has_ex),
        .data_sram_data_ok(a_data_ok), .data_sram_rdata(a_data_sram_rdata),
        .ws_allowin(a_ws_allowin), .wb_flush(a_wb_flush),
        .ms_to_ws_valid(a_ms_to_ws_valid), .ms_to_ws_payload(a_ms_to_ws_payload),
        .ms_to_ws_gr_we(a_ms_to_ws_gr_we), .ms_to_ws_dest(a_ms_to_ws_dest),
        .ms_final_result(a_ms_final_result), .ms_ex_valid(a_ms_ex_valid),
        .ms_fwd_valid(a_ms_fwd_valid), .ms_fwd_stall(a_ms_fwd_stall),
        .ms_outst_ovf(a_ms_outst_ovf)
    );

    // ---------------- instance b (64-bit, MAX_OUTST=1) ----------------
    logic         b_reset;
    logic         b_es_to_ms_valid, b_ms_allowin;
    logic [7:0]   b_es_to_ms_payload, b_ms_to_ws_payload;
    logic         b_es_gr_we, b_es_mem_req, b_es_is_load, b_es_ld_sign, b_es_has_ex;
    logic [4:0]   b_es_dest, b_ms_to_ws_dest;
    logic [1:0]   b_es_ld_size;
    logic [63:0]  b_es_exe_result, b_data_sram_rdata, b_ms_final_result;
    logic         b_data_ok, b_ws_allowin, b_wb_flush;
    logic         b_ms_to_ws_valid, b_ms_to_ws_gr_we, b_ms_ex_valid;
    logic         b_ms_fwd_valid, b_ms_fwd_stall, b_ms_outst_ovf;

    mem_resp_stage #(.DATA_W(64), .PAYLOAD_W(8), .MAX_OUTST(1)) dut_b (
        .clk(clk), .reset(b_reset),
        .es_to_ms_valid(b_es_to_ms_valid), .ms_allowin(b_ms_allowin),
        .es_to_ms_payload(b_es_to_ms_payload), .es_gr_we(b_es_gr_we),
        .es_dest(b_es_dest), .es_mem_req(b_es_mem_req), .es_is_load(b_es_is_load),
        .es_ld_size(b_es_ld_size), .es_ld_sign(b_es_ld_sign),
        .es_exe_result(b_es_exe_result), .es_has_ex(b_es_has_ex),
        .data_sram_data_ok(b_data_ok), .data_sram_rdata(b_data_sram_rdata),
        .ws_allowin(b_ws_allowin), .wb_flush(b_wb_flush),
        .ms_to_ws_valid(b_ms_to_ws_valid), .ms_to_ws_payload(b_ms_to_ws_payload),
        .ms_to_ws_gr_we(b_ms_to_ws_gr_we), .ms_to_ws_dest(b_ms_to_ws_dest),
        .ms_final_result(b_ms_final_result), .ms_ex_valid(b_ms_ex_valid),
        .ms_fwd_valid(b_ms_fwd_valid), .ms_fwd_stall(b_ms_fwd_stall),
        .ms_outst_ovf(b_ms_outst_ovf)
    );

    // ---------------- scoreboard state ----------------
    logic [37:0] exp_q[$];   // {gr_we, dest, result}
    logic [37:0] exp_e;
    bit          owed;
    logic [31:0] owed_data;
    bit          acc;
    int          kind;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference load extraction from the arithmetic definition: pick the
    // naturally aligned field containing the offset, then extend.
    function automatic logic [63:0] ref_load(input int w, input int size, input bit sign,
                                             input int off, input logic [63:0] rdata);
        longint unsigned d     = rdata;
        int              bytes = (size == 3) ? 8 : (1 << size);
        int              base  = off - (off % bytes);
        longint unsigned full  = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFFFF_FFFF;
        longint unsigned mask;
        longint unsigned v;
        if (bytes == 8) return d;
        mask = (64'd1 << (8 * bytes)) - 1;
        v    = (d >> (8 * base)) & mask;
        if (sign && (v > (mask >> 1))) v = v + (full - mask);
        return v;
    endfunction

    task automatic a_idle();
        a_es_to_ms_valid = 1'b0;
        a_data_ok        = 1'b0;
        a_wb_flush       = 1'b0;
        a_ws_allowin     = 1'b1;
    endtask

    task automatic a_offer(input bit gr_we, input logic [4:0] dest, input bit mem_req,
                           input bit is_load, input logic [1:0] size, input bit sign,
                           input logic [31:0] exe, input bit has_ex);
        a_es_to_ms_valid = 1'b1;
        a_es_gr_we       = gr_we;
        a_es_dest        = dest;
        a_es_mem_req     = mem_req;
        a_es_is_load     = is_load;
        a_es_ld_size     = size;
        a_es_ld_sign     = sign;
        a_es_exe_result  = exe;
        a_es_has_ex      = has_ex;
    endtask

    task automatic b_offer(input bit mem_req, input logic [1:0] size, input bit sign,
                           input logic [63:0] exe);
        b_es_to_ms_valid = 1'b1;
        b_es_gr_we       = 1'b1;
        b_es_dest        = 5'd9;
        b_es_mem_req     = mem_req;
        b_es_is_load     = mem_req;
        b_es_ld_size     = size;
        b_es_ld_sign     = sign;
        b_es_exe_result  = exe;
        b_es_has_ex      = 1'b0;
    endtask

    initial begin
        // ---------------- reset ----------------
        a_reset = 1'b1; b_reset = 1'b1;
        a_idle();
        a_es_to_ms_payload = '0; a_es_gr_we = 1'b0; a_es_dest = '0; a_es_mem_req = 1'b0;
        a_es_is_load = 1'b0; a_es_ld_size = '0; a_es_ld_sign = 1'b0; a_es_exe_result = '0;
        a_es_has_ex = 1'b0; a_data_sram_rdata = '0;
        b_es_to_ms_valid = 1'b0; b_data_ok = 1'b0; b_wb_flush = 1'b0; b_ws_allowin = 1'b1;
        b_es_to_ms_payload = 8'h5A; b_es_gr_we = 1'b0; b_es_dest = '0; b_es_mem_req = 1'b0;
        b_es_is_load = 1'b0; b_es_ld_size = '0; b_es_ld_sign = 1'b0; b_es_exe_result = '0;
        b_es_has_ex = 1'b0; b_data_sram_rdata = '0;
        owed = 1'b0; owed_data = '0;
        cyc(); cyc();
        a_reset = 1'b0; b_reset = 1'b0;
        #1;
        chk("rst_to_ws_valid", a_ms_to_ws_valid, 0);
        chk("rst_allowin", a_ms_allowin, 1);
        chk("rst_ex_valid", a_ms_ex_valid, 0);
        chk("rst_fwd_valid", a_ms_fwd_valid, 0);
        chk("rst_fwd_stall", a_ms_fwd_stall, 0);
        chk("rst_ovf", a_ms_outst_ovf, 0);
        chk("rst_b_to_ws_valid", b_ms_to_ws_valid, 0);

        // ---------------- word load, 3 waiting cycles ----------------
        a_es_to_ms_payload = '0;
        a_es_to_ms_payload[63:0] = 64'h0123_4567_89AB_CDEF;
        a_offer(1, 5'd5, 1, 1, 2'd2, 0, 32'h0000_1000, 0);
        cyc();
        a_es_to_ms_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("ldw_stall", a_ms_fwd_stall, 1);
            chk("ldw_wait_valid", a_ms_to_ws_valid, 0);
            cyc();
        end
        a_data_ok = 1'b1; a_data_sram_rdata = 32'h8000_00F0;
        #1;
        chk("ldw_valid", a_ms_to_ws_valid, 1);
        chk("ldw_result", a_ms_final_result, 32'h8000_00F0);
        chk("ldw_fwd_valid", a_ms_fwd_valid, 1);
        chk("ldw_stall_off", a_ms_fwd_stall, 0);
        chk("ldw_payload", a_ms_to_ws_payload[63:0], 64'h0123_4567_89AB_CDEF);
        chk("ldw_dest", a_ms_to_ws_dest, 5);
        cyc();
        a_data_ok = 1'b0;
        #1;
        chk("ldw_gone", a_ms_to_ws_valid, 0);

        // ---------------- ld.b signed / ld.hu ----------------
        a_offer(1, 5'd6, 1, 1, 2'd0, 1, 32'h0000_2003, 0);
        cyc();
        a_es_to_ms_valid = 1'b0;
        a_data_ok = 1'b1; a_data_sram_rdata = 32'h8512_3456;
        #1;
        chk("ldb_result", a_ms_final_result, 32'hFFFF_FF85);
        chk("ldb_valid", a_ms_to_ws_valid, 1);
        cyc();
        a_data_ok = 1'b0;
        a_offer(1, 5'd6, 1, 1, 2'd1, 0, 32'h0000_2002, 0);
        cyc();
        a_es_to_ms_valid = 1'b0;
        a_data_ok = 1'b1; a_data_sram_rdata = 32'h8001_ABCD;
        #1;
        chk("ldhu_result", a_ms_final_result, 32'h0000_8001);
        cyc();
        a_data_ok = 1'b0;

        // ---------------- flush with pending load in MS and in EX ----------------
        a_offer(1, 5'd8, 1, 1, 2'd2, 0, 32'h0000_3000, 0);
        cyc();
        a_es_to_ms_valid = 1'b0;
        cyc();
        a_offer(1, 5'd8, 1, 1, 2'd2, 0, 32'h0000_3004, 0);
        a_wb_flush = 1'b1;
        #1;
        chk("fl_to_ws_valid", a_ms_to_ws_valid, 0);
        cyc();
        a_wb_flush = 1'b0; a_es_to_ms_valid = 1'b0;
        #1;
        chk("fl_cnt2", dut_a.discard_cnt, 2);
        chk("fl_emptied", a_ms_fwd_stall, 0);
        a_offer(1, 5'd10, 1, 1, 2'd2, 0, 32'h0000_3008, 0);
        cyc();
        a_es_to_ms_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            a_data_ok = 1'b1; a_data_sram_rdata = 32'hDEAD_0001 + i;
            #1;
            chk("fl_drop_valid", a_ms_to_ws_valid, 0);
            chk("fl_drop_stall", a_ms_fwd_stall, 1);
            cyc();
        end
        #1;
        chk("fl_cnt0", dut_a.discard_cnt, 0);
        a_data_sram_rdata = 32'h1234_5678;
        #1;
        chk("fl_third_valid", a_ms_to_ws_valid, 1);
        chk("fl_third_result", a_ms_final_result, 32'h1234_5678);
        cyc();
        a_data_ok = 1'b0;

        // ---------------- back-pressure from WB ----------------
        a_offer(1, 5'd11, 1, 1, 2'd2, 0, 32'h0000_4000, 0);
        cyc();
        a_es_to_ms_valid = 1'b0;
        a_ws_allowin = 1'b0; a_data_ok = 1'b1; a_data_sram_rdata = 32'hCAFE_F00D;
        #1;
        chk("bp_valid0", a_ms_to_ws_valid, 1);
        chk("bp_allowin0", a_ms_allowin, 0);
        cyc();
        a_data_ok = 1'b0; a_data_sram_rdata = 32'h0BAD_0BAD;
        a_offer(1, 5'd7, 0, 0, 2'd2, 0, 32'h1111_2222, 0);
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("bp_hold_valid", a_ms_to_ws_valid, 1);
            chk("bp_hold_result", a_ms_final_result, 32'hCAFE_F00D);
            chk("bp_hold_allowin", a_ms_allowin, 0);
            cyc();
        end
        a_ws_allowin = 1'b1;
        #1;
        chk("bp_release_allowin", a_ms_allowin, 1);
        cyc();
        a_es_to_ms_valid = 1'b0;
        #1;
        chk("bp_next_result", a_ms_final_result, 32'h1111_2222);
        chk("bp_next_dest", a_ms_to_ws_dest, 7);
        chk("bp_next_valid", a_ms_to_ws_valid, 1);
        cyc();

        // ---------------- exception entry then flush ----------------
        a_ws_allowin = 1'b0;
        a_offer(0, 5'd0, 0, 0, 2'd0, 0, 32'h0000_5000, 1);
        cyc();
        a_es_to_ms_valid = 1'b0;
        #1;
        chk("ex_valid", a_ms_ex_valid, 1);
        chk("ex_ready_go", a_ms_to_ws_valid, 1);
        a_wb_flush = 1'b1;
        #1;
        chk("ex_flush_mask", a_ms_to_ws_valid, 0);
        cyc();
        a_wb_flush = 1'b0; a_ws_allowin = 1'b1;
        #1;
        chk("ex_cleared", a_ms_ex_valid, 0);
        chk("ex_cnt_same", dut_a.discard_cnt, 0);

        // ---------------- reset in the middle of a discard ----------------
        a_offer(1, 5'd3, 1, 1, 2'd2, 0, 32'h0000_6000, 0);
        cyc();
        a_es_to_ms_valid = 1'b0;
        a_wb_flush = 1'b1;
        cyc();
        a_wb_flush = 1'b0;
        #1;
        chk("mr_cnt1", dut_a.discard_cnt, 1);
        a_reset = 1'b1;
        cyc();
        a_reset = 1'b0;
        #1;
        chk("mr_cnt0", dut_a.discard_cnt, 0);
        a_data_ok = 1'b1; a_data_sram_rdata = 32'h7777_7777;
        #1;
        chk("mr_resp_ignored", a_ms_to_ws_valid, 0);
        cyc();
        a_data_ok = 1'b0;
        #1;
        chk("mr_cnt_still0", dut_a.discard_cnt, 0);

        // ---------------- 64-bit instance ----------------
        b_offer(1, 2'd2, 1, 64'h0000_0000_0000_1004);
        cyc();
        b_es_to_ms_valid = 1'b0;
        b_data_ok = 1'b1; b_data_sram_rdata = 64'h8000_0000_1234_5678;
        #1;
        chk("b_ldw_result", b_ms_final_result, 64'hFFFF_FFFF_8000_0000);
        chk("b_payload", b_ms_to_ws_payload, 8'h5A);
        cyc();
        b_data_ok = 1'b0;
        b_offer(1, 2'd3, 0, 64'h0000_0000_0000_2000);
        cyc();
        b_es_to_ms_valid = 1'b0;
        b_data_ok = 1'b1; b_data_sram_rdata = 64'hFEDC_BA98_7654_3210;
        #1;
        chk("b_ldd_result", b_ms_final_result, 64'hFEDC_BA98_7654_3210);
        cyc();
        b_data_ok = 1'b0;
        b_offer(1, 2'd2, 0, 64'h0000_0000_0000_3000);
        cyc();
        b_offer(1, 2'd2, 0, 64'h0000_0000_0000_3008);
        b_wb_flush = 1'b1;
        cyc();
        b_wb_flush = 1'b0; b_es_to_ms_valid = 1'b0;
        #1;
        chk("b_sat_cnt", dut_b.discard_cnt, 1);
        chk("b_ovf_set", b_ms_outst_ovf, 1);
        b_data_ok = 1'b1;
        cyc();
        b_data_ok = 1'b0;
        #1;
        chk("b_cnt_drained", dut_b.discard_cnt, 0);
        chk("b_ovf_sticky", b_ms_outst_ovf, 1);
        b_reset = 1'b1;
        cyc();
        b_reset = 1'b0;
        #1;
        chk("b_ovf_reset", b_ms_outst_ovf, 0);

        // ---------------- randomized traffic on instance a ----------------
        a_idle();
        exp_q.delete();
        owed = 1'b0;
        for (int c = 0; c < 700; c++) begin
            if (!a_es_to_ms_valid && (c < 600) && ($urandom_range(0, 2) != 0)) begin
                kind = $urandom_range(0, 2);
                a_offer(kind != 2, 5'($urandom_range(1, 31)), kind != 0, kind == 1,
                        2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), $urandom, 0);
            end
            a_ws_allowin      = (c >= 600) || ($urandom_range(0, 3) != 0);
            a_data_ok         = owed && ($urandom_range(0, 1) == 1);
            a_data_sram_rdata = a_data_ok ? owed_data : $urandom;
            #1;
            if (a_ms_to_ws_valid && a_ws_allowin) begin
                if (exp_q.size() == 0) begin
                    chk("rnd_spurious_out", a_ms_to_ws_valid, 0);
                end else begin
                    exp_e = exp_q.pop_front();
                    chk("rnd_out", {a_ms_to_ws_gr_we, a_ms_to_ws_dest, a_ms_final_result}, exp_e);
                end
            end
            acc = a_es_to_ms_valid && a_ms_allowin;
            if (a_data_ok) owed = 1'b0;
            if (acc) begin
                if (a_es_mem_req) begin
                    owed      = 1'b1;
                    owed_data = $urandom;
                end
                exp_q.push_back({a_es_gr_we, a_es_dest,
                    a_es_is_load ? 32'(ref_load(32, int'(a_es_ld_size), a_es_ld_sign,
                                                int'(a_es_exe_result[1:0]), {32'd0, owed_data}))
                                 : a_es_exe_result});
            end
            cyc();
            if (acc) a_es_to_ms_valid = 1'b0;
        end
        chk("rnd_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
